fifo_sram_ctrl: RTL and testbench

- Synchronous FIFO controller placed directly upstream of the two-port SRAM model. It drives the SRAM write and read ports and captures the registered SRAM read data.
- Exposes valid/ready push and pop interfaces to the surrounding datapath.
- A 2-entry output buffer hides the 1-cycle SRAM read latency, so the block sustains one push and one pop per cycle.

---
 rtl/fifo_sram_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_fifo_sram_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_ctrl.sv
// fifo_sram_ctrl: synchronous FIFO controller in front of a two-port SRAM
// that has a registered (1-cycle) read port.
//
// A 2-entry output buffer fed by prefetch reads hides the SRAM read latency,
// so one push and one pop per cycle are sustained.
//
// Optional macro FIFO_SRAM_CTRL_CHK_EN compiles in simulation-only sanity
// checks that print "FIFO ERROR" and end the simulation.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_val_i/wr_rdy_o/wr_dat_i   push handshake and data
//   rd_val_o/rd_rdy_i/rd_dat_o   pop handshake and head data
//   cnt_o           total words held (SRAM + in flight + output buffer)
//   sram_wr_*       SRAM write port (valid, address, data)
//   sram_rd_val_o/sram_rd_adr_o  SRAM read request
//   sram_rd_dat_i   SRAM registered read data, valid one cycle after request

module fifo_sram_ctrl #(
    parameter  int unsigned SIZE    = 64,
    parameter  int unsigned DATA_WD = 32,
    localparam int unsigned SIZE_WD = $clog2(SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_val_i,
    output logic               wr_rdy_o,
    input  logic [DATA_WD-1:0] wr_dat_i,
    output logic               rd_val_o,
    input  logic               rd_rdy_i,
    output logic [DATA_WD-1:0] rd_dat_o,
    output logic [SIZE_WD+1:0] cnt_o,
    output logic               sram_wr_val_o,
    output logic [SIZE_WD-1:0] sram_wr_adr_o,
    output logic [DATA_WD-1:0] sram_wr_dat_o,
    output logic               sram_rd_val_o,
    output logic [SIZE_WD-1:0] sram_rd_adr_o,
    input  logic [DATA_WD-1:0] sram_rd_dat_i
);

    localparam int unsigned SCNT_WD = SIZE_WD + 1;
    localparam int unsigned TCNT_WD = SIZE_WD + 2;

    // Registered state
    logic [SIZE_WD-1:0] wr_ptr;
    logic [SIZE_WD-1:0] rd_ptr;
    logic [SCNT_WD-1:0] sram_cnt;
    logic               inflight;
    logic [1:0]         ob_cnt;
    logic [DATA_WD-1:0] ob_head;
    logic [DATA_WD-1:0] ob_tail;

    // Next-state / handshake signals
    logic               push;
    logic               pop;
    logic               issue;
    logic [2:0]         ob_sum;
    logic [1:0]         ob_fill;
    logic [SCNT_WD-1:0] sram_cnt_nxt;
    logic [1:0]         ob_cnt_nxt;
    logic [TCNT_WD-1:0] cnt_nxt;
    logic               wr_rdy_nxt;
    logic [DATA_WD-1:0] ob_head_nxt;
    logic [DATA_WD-1:0] ob_tail_nxt;

    // Handshakes and prefetch decision
    always_comb begin
        push   = wr_val_i & wr_rdy_o;
        pop    = rd_val_o & rd_rdy_i;
        // Words that will sit in the output buffer next cycle if no new read issues
        ob_sum = 3'(ob_cnt) + 3'(inflight) - 3'(pop);
        issue  = (sram_cnt != '0) && (ob_sum < 3'd2);
    end

    // Occupancy bookkeeping
    always_comb begin
        sram_cnt_nxt = sram_cnt + SCNT_WD'(push) - SCNT_WD'(issue);
        ob_cnt_nxt   = ob_sum[1:0];
        cnt_nxt      = TCNT_WD'(sram_cnt_nxt) + TCNT_WD'(issue) + TCNT_WD'(ob_cnt_nxt);
        // An issue in the same cycle frees an entry, but ready only rises next cycle
        wr_rdy_nxt   = (sram_cnt_nxt < SCNT_WD'(SIZE));
    end

    // Output buffer update: shift on pop, then land captured data in the first free slot
    always_comb begin
        ob_head_nxt = ob_head;
        ob_tail_nxt = ob_tail;
        ob_fill     = ob_cnt - 2'(pop);
        if (pop) begin
            ob_head_nxt = ob_tail;
        end
        // SRAM read data is only valid in this cycle, so capture is unconditional
        if (inflight) begin
            if (ob_fill == 2'd0) begin
                ob_head_nxt = sram_rd_dat_i;
            end else begin
                ob_tail_nxt = sram_rd_dat_i;
            end
        end
    end

    // SRAM port drive
    always_comb begin
        sram_wr_val_o = push;
        sram_wr_adr_o = wr_ptr;
        sram_wr_dat_o = wr_dat_i;
        sram_rd_val_o = issue;
        sram_rd_adr_o = rd_ptr;
    end

    // Pointers and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= 1'b0;
            ob_cnt   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + SIZE_WD'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + SIZE_WD'(1);
            end
            sram_cnt <= sram_cnt_nxt;
            inflight <= issue;
            ob_cnt   <= ob_cnt_nxt;
        end
    end

    // Output buffer storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ob_head <= '0;
            ob_tail <= '0;
        end else begin
            ob_head <= ob_head_nxt;
            ob_tail <= ob_tail_nxt;
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_rdy_o <= 1'b1;
            rd_val_o <= 1'b0;
            cnt_o    <= '0;
        end else begin
            wr_rdy_o <= wr_rdy_nxt;
            rd_val_o <= (ob_cnt_nxt != 2'd0);
            cnt_o    <= cnt_nxt;
        end
    end

    assign rd_dat_o = ob_head;

`ifdef FIFO_SRAM_CTRL_CHK_EN
    // Simulation-only sanity checks
    task automatic fifo_error(input string msg);
        $display("FIFO ERROR: %m: %s", msg);
        #1000;
        $finish;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (wr_val_i && !wr_rdy_o) begin
                fifo_error("push attempted while full");
            end
            if (sram_cnt > SCNT_WD'(SIZE)) begin
                fifo_error("sram_cnt exceeds SIZE");
            end
            if (ob_cnt > 2'd2) begin
                fifo_error("ob_cnt exceeds 2");
            end
            if (rd_val_o && $isunknown(rd_dat_o)) begin
                fifo_error("X on rd_dat_o while rd_val_o");
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// Self-checking bench for fifo_sram_ctrl: a two-port SRAM model with a
// registered read port, and a queue-based reference of the FIFO contents.
module tb_fifo_sram_ctrl;

    localparam int SIZE    = 64;
    localparam int DATA_WD = 32;
    localparam int SIZE_WD = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_val = 1'b0;
    logic               wr_rdy;
    logic [DATA_WD-1:0] wr_dat = '0;
    logic               rd_val;
    logic               rd_rdy = 1'b0;
    logic [DATA_WD-1:0] rd_dat;
    logic [SIZE_WD+1:0] cnt;
    logic               sram_wr_val;
    logic [SIZE_WD-1:0] sram_wr_adr;
    logic [DATA_WD-1:0] sram_wr_dat;
    logic               sram_rd_val;
    logic [SIZE_WD-1:0] sram_rd_adr;
    logic [DATA_WD-1:0] sram_rd_dat = '0;

    fifo_sram_ctrl #(.SIZE(SIZE), .DATA_WD(DATA_WD)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_val_i      (wr_val),
        .wr_rdy_o      (wr_rdy),
        .wr_dat_i      (wr_dat),
        .rd_val_o      (rd_val),
        .rd_rdy_i      (rd_rdy),
        .rd_dat_o      (rd_dat),
        .cnt_o         (cnt),
        .sram_wr_val_o (sram_wr_val),
        .sram_wr_adr_o (sram_wr_adr),
        .sram_wr_dat_o (sram_wr_dat),
        .sram_rd_val_o (sram_rd_val),
        .sram_rd_adr_o (sram_rd_adr),
        .sram_rd_dat_i (sram_rd_dat)
    );

    always #5 clk = ~clk;

    // SRAM model: read data valid only the cycle after a read, garbage otherwise
    logic [DATA_WD-1:0] mem [SIZE];
    always @(posedge clk) begin
        if (sram_wr_val) mem[sram_wr_adr] <= sram_wr_dat;
        if (sram_rd_val) sram_rd_dat <= mem[sram_rd_adr];
        else             sram_rd_dat <= $urandom;
    end

    // Reference model: words held, in push order, and words still in the SRAM
    logic [DATA_WD-1:0] q[$];
    int sram_occ = 0;
    int n_chk    = 0;
    int n_fail   = 0;
    logic acc, popped;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, update the model
    task automatic step(input logic wv, input logic [DATA_WD-1:0] wd, input logic rr,
                        output logic a, output logic p);
        logic [DATA_WD-1:0] exp_d;
        @(negedge clk);
        wr_val = wv;
        wr_dat = wd;
        rd_rdy = rr;
        #1;
        chk("cnt", 64'(cnt), 64'(q.size()));
        if (q.size() < SIZE)      chk("wr_rdy_room", 64'(wr_rdy), 64'd1);
        if (q.size() == SIZE + 2) chk("wr_rdy_full", 64'(wr_rdy), 64'd0);
        if (q.size() == 0)        chk("rd_val_empty", 64'(rd_val), 64'd0);
        if (sram_rd_val)          chk("issue_nonempty", 64'(sram_occ != 0), 64'd1);
        chk("sram_wr_val", 64'(sram_wr_val), 64'(wv & wr_rdy));
        a = wv & wr_rdy;
        p = rd_val & rr;
        if (p) begin
            chk("pop_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                exp_d = q.pop_front();
                chk("pop_data", 64'(rd_dat), 64'(exp_d));
            end
        end
        if (a) begin
            chk("sram_wr_dat", 64'(sram_wr_dat), 64'(wd));
            q.push_back(wd);
        end
        sram_occ = sram_occ + int'(a) - int'(sram_rd_val);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            step(1'b0, '0, 1'b1, acc, popped);
            n++;
        end
        chk(tag, 64'(q.size()), 64'd0);
        step(1'b0, '0, 1'b0, acc, popped);
        step(1'b0, '0, 1'b0, acc, popped);
    endtask

    initial begin
        int accepted;
        int gaps;
        int npops;
        logic wv;
        logic rr;
        logic got;

        // Reset values
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wr_rdy", 64'(wr_rdy), 64'd1);
        chk("rst_rd_val", 64'(rd_val), 64'd0);
        chk("rst_rd_dat", 64'(rd_dat), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_sram_rd_val", 64'(sram_rd_val), 64'd0);

        // Single word latency: push in cycle 0, head valid in cycle 3
        step(1'b1, 32'hA5, 1'b0, acc, popped);
        chk("t1_acc", 64'(acc), 64'd1);
        step(1'b0, '0, 1'b0, acc, popped);
        chk("t1_c1_rd_val", 64'(rd_val), 64'd0);
        chk("t1_c1_cnt", 64'(cnt), 64'd1);
        step(1'b0, '0, 1'b0, acc, popped);
        chk("t1_c2_rd_val", 64'(rd_val), 64'd0);
        step(1'b0, '0, 1'b0, acc, popped);
        chk("t1_c3_rd_val", 64'(rd_val), 64'd1);
        chk("t1_c3_rd_dat", 64'(rd_dat), 64'hA5);
        drain("t1_drain");

        // Fill to SIZE+2 with no pops, then drain in order
        accepted = 0;
        for (int i = 0; i < 100; i++) begin
            step(accepted < SIZE + 2, DATA_WD'(accepted), 1'b0, acc, popped);
            if (acc) accepted++;
        end
        chk("t2_accepted", 64'(accepted), 64'(SIZE + 2));
        chk("t2_full_wr_rdy", 64'(wr_rdy), 64'd0);
        chk("t2_full_cnt", 64'(cnt), 64'(SIZE + 2));
        drain("t2_drain");
        chk("t2_empty_wr_rdy", 64'(wr_rdy), 64'd1);
        chk("t2_empty_cnt", 64'(cnt), 64'd0);

        // Streaming: one pop per cycle after the 3-cycle fill
        gaps  = 0;
        npops = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, DATA_WD'(i), 1'b1, acc, popped);
            if (i >= 3 && !popped) gaps++;
            if (popped) npops++;
        end
        chk("t3_gaps", 64'(gaps), 64'd0);
        chk("t3_pops", 64'(npops), 64'd997);
        drain("t3_drain");

        // Random traffic, 30% toggle probability per cycle on each handshake input
        wv = 1'b0;
        rr = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(99) < 30) wv = ~wv;
            if ($urandom_range(99) < 30) rr = ~rr;
            step(wv, DATA_WD'($urandom), rr, acc, popped);
        end
        drain("t4_drain");

        // Asynchronous reset mid-operation discards everything
        for (int i = 0; i < 3; i++) step(1'b1, DATA_WD'(32'h100 + i), 1'b0, acc, popped);
        step(1'b0, '0, 1'b0, acc, popped);
        chk("t5_pre_cnt", 64'(cnt), 64'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_wr_rdy", 64'(wr_rdy), 64'd1);
        chk("t5_rst_rd_val", 64'(rd_val), 64'd0);
        chk("t5_rst_rd_dat", 64'(rd_dat), 64'd0);
        chk("t5_rst_cnt", 64'(cnt), 64'd0);
        q.delete();
        sram_occ = 0;
        wr_val = 1'b0;
        rd_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h5A, 1'b0, acc, popped);
        chk("t5_acc", 64'(acc), 64'd1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b0, '0, 1'b1, acc, popped);
            got = popped;
        end
        chk("t5_popped", 64'(got), 64'd1);
        drain("t5_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
